// File: rtl/updown_decoder.sv
// Decodes the direction of an external up/down counter from successive samples,
// flagging illegal steps and tracking error and same-direction run counts.
module updown_decoder #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] count,
    output logic             dir_valid,
    output logic             up,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [RUN_W-1:0] run_len
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] delta;
    logic             step_up;
    logic             step_dn;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_ONE;
    endfunction

    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
        return (v == {RUN_W{1'b1}}) ? v : v + RUN_ONE;
    endfunction

    // Modular difference makes wrap-around steps decode like any other unit step.
    assign delta   = count - prev;
    assign step_up = (delta == STEP_ONE);
    assign step_dn = (delta == {WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            prev      <= '0;
            dir_valid <= 1'b0;
            up        <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
            run_len   <= '0;
        end else if (clear) begin
            state     <= EMPTY;
            prev      <= '0;
            dir_valid <= 1'b0;
            up        <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
            run_len   <= '0;
        end else begin
            dir_valid <= 1'b0;
            step_err  <= 1'b0;
            if (en) begin
                prev <= count;
                if (state == EMPTY) begin
                    state <= TRACK;
                end else if (step_up || step_dn) begin
                    dir_valid <= 1'b1;
                    up        <= step_up;
                    // run_len of zero marks "no previous legal step in this run".
                    if ((run_len != '0) && (up == step_up))
                        run_len <= run_sat_inc(run_len);
                    else
                        run_len <= RUN_ONE;
                end else begin
                    step_err <= 1'b1;
                    err_cnt  <= err_sat_inc(err_cnt);
                    run_len  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_decoder.sv
// Scoreboard bench for updown_decoder: stimulus queues expected pulses, a monitor
// pops and compares them whenever the DUT raises dir_valid or step_err.
module tb_updown_decoder;

    typedef struct packed {
        logic       dv;
        logic       up;
        logic       se;
        logic [7:0] err;
        logic [7:0] run;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] count = '0;
    logic       dir_valid, up, step_err;
    logic [7:0] err_cnt, run_len;

    logic       en2 = 1'b0;
    logic       clear2 = 1'b0;
    logic [3:0] count2 = '0;
    logic       dir_valid2, up2, step_err2;
    logic [1:0] err_cnt2, run_len2;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    updown_decoder #(.WIDTH(4), .ERR_W(8), .RUN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .count(count),
        .dir_valid(dir_valid), .up(up), .step_err(step_err),
        .err_cnt(err_cnt), .run_len(run_len)
    );

    updown_decoder #(.WIDTH(4), .ERR_W(2), .RUN_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en2), .clear(clear2), .count(count2),
        .dir_valid(dir_valid2), .up(up2), .step_err(step_err2),
        .err_cnt(err_cnt2), .run_len(run_len2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input logic [3:0] c);
        @(negedge clk);
        clear = 1'b0;
        en    = 1'b1;
        count = c;
    endtask

    task automatic step_exp(input logic [3:0] c, input logic dv, input logic u,
                            input logic se, input logic [7:0] e, input logic [7:0] r);
        exp_t x;
        step(c);
        x = '{dv: dv, up: u, se: se, err: e, run: r};
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear = 1'b0;
            en    = 1'b0;
            en2   = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        en    = 1'b0;
    endtask

    task automatic step2(input logic [3:0] c);
        @(negedge clk);
        en2    = 1'b1;
        count2 = c;
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (dir_valid || step_err) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: dv=%0b se=%0b up=%0b run=%0d with nothing expected",
                         dir_valid, step_err, up, run_len);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse{dv,up,se,err,run}",
                      {13'd0, dir_valid, up, step_err, err_cnt, run_len},
                      {13'd0, e});
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_dir_valid", {31'd0, dir_valid}, 32'd0);
        check("reset_up",        {31'd0, up},        32'd0);
        check("reset_step_err",  {31'd0, step_err},  32'd0);
        check("reset_err_cnt",   {24'd0, err_cnt},   32'd0);
        check("reset_run_len",   {24'd0, run_len},   32'd0);
        rst_n = 1'b1;

        // Steady counting up
        step(4'd3);
        step_exp(4'd4, 1, 1, 0, 8'd0, 8'd1);
        step_exp(4'd5, 1, 1, 0, 8'd0, 8'd2);
        step_exp(4'd6, 1, 1, 0, 8'd0, 8'd3);

        // Wrap up across 15->0, then back down across 0->15
        do_clear();
        step(4'd14);
        step_exp(4'd15, 1, 1, 0, 8'd0, 8'd1);
        step_exp(4'd0,  1, 1, 0, 8'd0, 8'd2);
        step_exp(4'd1,  1, 1, 0, 8'd0, 8'd3);
        step_exp(4'd0,  1, 0, 0, 8'd0, 8'd1);
        step_exp(4'd15, 1, 0, 0, 8'd0, 8'd2);

        // Illegal steps: repeat (d=0) and jump (d=4), then recovery
        do_clear();
        step(4'd5);
        step_exp(4'd5,  0, 0, 1, 8'd1, 8'd0);
        step_exp(4'd9,  0, 0, 1, 8'd2, 8'd0);
        step_exp(4'd10, 1, 1, 0, 8'd2, 8'd1);

        // en=0 gap: state holds, no pulses
        do_clear();
        step(4'd6);
        step_exp(4'd7, 1, 1, 0, 8'd0, 8'd1);
        idle(3);
        check("gap_up_hold",  {31'd0, up},      32'd1);
        check("gap_run_hold", {24'd0, run_len}, 32'd1);
        step_exp(4'd8, 1, 1, 0, 8'd0, 8'd2);
        step_exp(4'd9, 1, 1, 0, 8'd0, 8'd3);
        idle(1);
        check("pre_reset_run", {24'd0, run_len}, 32'd3);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_up",  {31'd0, up},      32'd0);
        check("async_rst_run", {24'd0, run_len}, 32'd0);
        check("async_rst_dv",  {31'd0, dir_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd4);
        step_exp(4'd5, 1, 1, 0, 8'd0, 8'd1);

        // Clear together with a sample: the sample is dropped
        @(negedge clk);
        clear = 1'b1;
        en    = 1'b1;
        count = 4'd2;
        idle(1);
        check("clear_up",  {31'd0, up},      32'd0);
        check("clear_run", {24'd0, run_len}, 32'd0);
        check("clear_err", {24'd0, err_cnt}, 32'd0);
        step(4'd3);
        step_exp(4'd4, 1, 1, 0, 8'd0, 8'd1);
        idle(2);

        // Saturation on the narrow instance
        for (int i = 0; i < 6; i++) step2(4'(i));
        idle(1);
        check("run_len_saturates", {30'd0, run_len2}, 32'd3);
        check("sat_up",            {31'd0, up2},      32'd1);
        for (int i = 0; i < 5; i++) step2(4'd5);
        idle(1);
        check("err_cnt_saturates", {30'd0, err_cnt2}, 32'd3);
        check("sat_run_after_err", {30'd0, run_len2}, 32'd0);

        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_decoder.md
UPDOWN_DECODER -- requirements
Module: updown_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the observed count; legal range 2..16.
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-003 The block SHALL have parameter RUN_W, default 8, giving the width of the run-length counter.
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-006 Port en  input  1  SHALL qualify count as a valid sample in the current cycle.
REQ-007 Port clear  input  1  SHALL be a synchronous restart of tracking and counters.
REQ-008 Port count  input  WIDTH  SHALL carry the counter value being decoded.
REQ-009 Port dir_valid  output  1  SHALL indicate that up is a decoded direction for the previous sample.
REQ-010 Port up  output  1  SHALL give the decoded direction: 1 = increment, 0 = decrement.
REQ-011 Port step_err  output  1  SHALL pulse for one cycle on an illegal step.
REQ-012 Port err_cnt  output  ERR_W  SHALL give the saturating count of illegal steps.
REQ-013 Port run_len  output  RUN_W  SHALL give the saturating count of consecutive same-direction steps.

Function
REQ-014 The FSM SHALL have two states: EMPTY (no reference sample held) and TRACK (prev register holds last sample).
REQ-015 In EMPTY with en=1, the block SHALL load prev<=count, go to TRACK, and assert no dir_valid or step_err.
REQ-016 In TRACK with en=1, the block SHALL compute d = (count - prev) mod 2^WIDTH and always load prev<=count.
REQ-017 d==1 SHALL register dir_valid=1, up=1; d==2^WIDTH-1 SHALL register dir_valid=1, up=0.
REQ-018 Wrap-around SHALL decode naturally: for WIDTH=4, prev=15 to count=0 SHALL be up, and prev=0 to count=15 SHALL be down.
REQ-019 d==0 or any other value SHALL register step_err=1 and dir_valid=0; up SHALL hold its last value; err_cnt SHALL increment, saturating at 2^ERR_W-1.
REQ-020 On an illegal step, run_len SHALL go to 0, and tracking SHALL resynchronise to the new sample.
REQ-021 On a legal step in the same direction as the previous legal step, run_len SHALL increment, saturating at 2^RUN_W-1.
REQ-022 On the first legal step after EMPTY or after an error, or on a direction change, run_len SHALL be set to 1.
REQ-023 All outputs SHALL be registered, with latency of exactly one clock from the sampling edge to the outputs.
REQ-024 dir_valid and step_err SHALL be single-cycle pulses, SHALL never both be 1, and SHALL be 0 in any cycle following en=0.
REQ-025 With en=0, prev, state, up, err_cnt and run_len SHALL hold.
REQ-026 clear=1 SHALL force EMPTY, err_cnt=0, run_len=0, dir_valid=0, step_err=0 and up=0 at the next edge.
REQ-027 clear SHALL take priority over a simultaneous en=1, and that sample SHALL be discarded.

Reset
REQ-028 rst_n=0 SHALL immediately force state=EMPTY, prev=0, dir_valid=0, up=0, step_err=0, err_cnt=0 and run_len=0, independent of clk.
REQ-029 Reset asserted mid-stream SHALL discard the held sample.
REQ-030 After release, the first en=1 sample SHALL only establish the reference, with no output pulse.

Verification
REQ-031 Stimulus: reset, then en=1 with count 3,4,5,6 -> required response: no pulse for 3; dir_valid=1, up=1 on the cycles after 4, 5 and 6; run_len reaches 3.
REQ-032 Stimulus: count 14,15,0,1, then 0,15 -> required response: up=1 across the wrap, then up=0 twice; run_len goes to 3, then 1, then 2.
REQ-033 Stimulus: count 5,5, then 5,9 -> required response: step_err=1 twice; err_cnt=2; run_len=0; the next sample 10 gives up=1 with run_len=1.
REQ-034 Stimulus: ERR_W=2 with 5 illegal steps -> required response: err_cnt saturates at 3.
REQ-035 Stimulus: en=0 gap of 3 cycles between samples 7 and 8 -> required response: no pulses during the gap; up=1 after 8; run_len continues.
REQ-036 Stimulus: rst_n low mid-cycle during TRACK -> required response: outputs cleared before the next edge. Stimulus: clear with en=1 and count=2, then 3 -> required response: 2 discarded; 3 becomes the reference with no pulse.
